// File: rtl/pin_input_port_if.sv
// pin_input_port_if: pin sample bus between the core (master) and the pin input port (slave).
interface pin_input_port_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] i_pins;
  logic             i_rd;
  logic [WIDTH-1:0] o_in;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic             o_valid;
  modport master (output i_pins, i_rd, input o_in, o_rise, o_fall, o_valid);
  modport slave  (input i_pins, i_rd, output o_in, o_rise, o_fall, o_valid);
endinterface

// File: rtl/pin_input_port.sv
// pin_input_port: synchronized, debounced pin inputs with sticky edge flags.
// Falling-edge flags exist only when PIN_INPUT_FALLING_EDGE_EN is defined.
module pin_input_port #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16000
) (
  input logic             i_clk,
  input logic             i_rst_n,
  pin_input_port_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, s2, din, rise, upd, rise_nxt;
  logic valid, valid_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.i_pins;
      s2 <= s1;
    end
  genvar n;
  generate
    for (n = 0; n < WIDTH; n++) begin : g_pin
      logic [CW-1:0] cnt;
      assign upd[n] = (s2[n] != din[n]) && (cnt == LAST);
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cnt <= '0;
        else cnt <= (s2[n] == din[n] || upd[n]) ? '0 : cnt + CW'(1);
    end
  endgenerate
  // a fresh edge wins over a read clearing the same bit
  assign rise_nxt = (bus.i_rd ? '0 : rise) | (upd & s2);
`ifdef PIN_INPUT_FALLING_EDGE_EN
  logic [WIDTH-1:0] fall, fall_nxt;
  assign fall_nxt  = (bus.i_rd ? '0 : fall) | (upd & ~s2);
  assign valid_nxt = |(rise_nxt | fall_nxt);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) fall <= '0;
    else fall <= fall_nxt;
  assign bus.o_fall = fall;
`else
  assign valid_nxt  = |rise_nxt;
  assign bus.o_fall = '0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      din   <= '0;
      rise  <= '0;
      valid <= 1'b0;
    end else begin
      din   <= din ^ upd;
      rise  <= rise_nxt;
      valid <= valid_nxt;
    end
  assign bus.o_in    = din;
  assign bus.o_rise  = rise;
  assign bus.o_valid = valid;
endmodule

// File: doc/pin_input_port.md
PIN_INPUT_PORT -- requirements
Module: pin_input_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of external input pins sampled.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16000 (1 ms at 16 MHz), giving the number of consecutive stable clocks before a level is accepted.
REQ-003 Port i_clk  input  1  system clock; the block has a single clock domain.
REQ-004 Port i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port i_pins  input  WIDTH  raw, asynchronous external pin levels.
REQ-006 Port i_rd  input  1  core read strobe; one-cycle pulse that consumes pending events.
REQ-007 Port o_in  output  WIDTH  debounced stable pin levels.
REQ-008 Port o_rise  output  WIDTH  sticky rising-edge event flags.
REQ-009 Port o_fall  output  WIDTH  sticky falling-edge event flags.
REQ-010 Port o_valid  output  1  high when any event flag is set.

Function
REQ-011 Each pin SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each pin SHALL have an independent debounce counter of width clog2(DEBOUNCE_CYCLES+1).
- Counter clears whenever the synchronized level equals o_in[n].
- Counter increments by 1 per clock while the synchronized level differs from o_in[n].
REQ-013 When the counter for pin n reaches DEBOUNCE_CYCLES-1 while the level still differs, o_in[n] SHALL take the synchronized level on the next clock and the counter SHALL clear.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES clocks SHALL NOT change o_in.
REQ-015 Latency from a stable change on i_pins to o_in SHALL be exactly 2 + DEBOUNCE_CYCLES clocks.
REQ-016 A 0->1 transition of o_in[n] SHALL set o_rise[n] on the same clock edge that o_in[n] updates.
REQ-017 A 1->0 transition of o_in[n] SHALL set o_fall[n] on the same clock edge, subject to REQ-024.
REQ-018 Event flags SHALL remain set until consumed by i_rd.
REQ-019 When i_rd=1, all event flags SHALL clear on that clock.
REQ-020 If a new edge and i_rd coincide on the same clock, the new edge's flag SHALL be set after that clock; set has priority over clear for that bit only.
REQ-021 o_valid SHALL be the registered OR of all o_rise and o_fall bits, valid in the same cycle as the flags.
REQ-022 An i_rd with no pending events SHALL be harmless.

Reset
REQ-023 While i_rst_n=0, all outputs and internal state SHALL be held at 0 immediately (asynchronously): synchronizers, counters, o_in, o_rise, o_fall, o_valid.
- Deassertion takes effect on the next i_clk edge.
- If a pin is held high through reset, the block SHALL debounce it to 1 and set o_rise.
- Reset mid-debounce SHALL discard the partial count.

Configuration
REQ-024 Macro PIN_INPUT_FALLING_EDGE_EN controls falling-edge detection.
- Defined: o_fall SHALL behave per REQ-017..REQ-020.
- Undefined: o_fall SHALL be constant 0, no fall-flag registers SHALL be instantiated, and o_valid SHALL reflect o_rise only.

Verification
REQ-025 DEBOUNCE_CYCLES=4, reset released, i_pins=8'h01 held -> o_in=8'h01, o_rise=8'h01, o_valid=1 exactly 6 clocks after the change; no change before that.
REQ-026 DEBOUNCE_CYCLES=4, i_pins[2] pulsed high for 3 clocks -> o_in, o_rise and o_valid stay 0 throughout.
REQ-027 o_rise=8'h01 pending, i_rd pulsed on the same clock that pin 3 debounces high -> o_rise=8'h08 next cycle, o_valid=1.
REQ-028 With PIN_INPUT_FALLING_EDGE_EN defined, pin 0 1->0 stable -> o_fall=8'h01; then i_rd -> o_fall=0, o_valid=0. Without the macro -> o_fall stays 0 and o_valid stays 0.
REQ-029 i_rst_n asserted mid-debounce with o_rise=8'hFF -> all outputs 0 asynchronously, before the next clock edge.
